booth_r4_mult: RTL and testbench

- Parametrised radix-4 (modified) Booth multiplier. It is the next generation of the team's radix-2 Booth datapath/FSM pair.
- Adds a configurable operand width, a per-transaction signed/unsigned mode, and valid/ready handshakes on both input and output with backpressure.
- Retires two multiplier bits per clock in a single posedge-clocked FSM+datapath. It sits between the operand source and the result consumer in the arithmetic unit.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_r4_ppgen.sv | 30 +++
 rtl/booth_r4_mult.sv | 107 ++++++++++
 tb/tb_booth_r4_mult.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and radix-4 recode helper for booth_r4_mult
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_PM   = 3'd1,
    SEL_P2M  = 3'd2,
    SEL_NM   = 3'd3,
    SEL_N2M  = 3'd4
  } booth_sel_t;

  // Triplet is {Q[1], Q[0], q_-1}.
  function automatic booth_sel_t booth_r4_decode(input logic [2:0] triplet);
    case (triplet)
      3'b001, 3'b010: return SEL_PM;
      3'b011:         return SEL_P2M;
      3'b100:         return SEL_N2M;
      3'b101, 3'b110: return SEL_NM;
      default:        return SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_ppgen.sv
// rtl/booth_r4_ppgen.sv - radix-4 Booth partial product selector
module booth_r4_ppgen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] m,
  input  logic [2:0]       triplet,
  output logic [WIDTH+2:0] pp
);

  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;

  // M is already WIDTH+2 bits two's complement, so 2M fits one bit wider.
  assign m1 = {m[WIDTH+1], m};
  assign m2 = {m, 1'b0};

  always_comb begin
    pp = '0;
    case (booth_r4_decode(triplet))
      SEL_PM:  pp = m1;
      SEL_P2M: pp = m2;
      SEL_NM:  pp = -m1;
      SEL_N2M: pp = -m2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult.sv
// rtl/booth_r4_mult.sv - sequential radix-4 Booth multiplier with valid/ready handshakes
module booth_r4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int ITER  = WIDTH / 2 + 1;
  localparam int CNT_W = $clog2(ITER + 1);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_r4_mult: WIDTH must be even and at least 4");
  end

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH+1:0]   m;
  logic [WIDTH+1:0]   q;
  logic               q_m1;
  logic [WIDTH+2:0]   h;

  logic [WIDTH+2:0]   pp;
  logic [WIDTH+2:0]   h_sum;
  logic [2*WIDTH+5:0] shift_in;
  logic [2*WIDTH+5:0] shifted;

  booth_r4_ppgen #(.WIDTH(WIDTH)) u_ppgen (
    .m       (m),
    .triplet ({q[1:0], q_m1}),
    .pp      (pp)
  );

  assign h_sum    = h + pp;
  assign shift_in = {h_sum, q, q_m1};
  assign shifted  = $signed(shift_in) >>> 2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      cnt       <= '0;
      m         <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      h         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Mode is folded into the extension; nothing downstream needs it.
            m        <= signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            q        <= signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
            q_m1     <= 1'b0;
            h        <= '0;
            cnt      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          h    <= shifted[2*WIDTH+5:WIDTH+3];
          q    <= shifted[WIDTH+2:1];
          q_m1 <= shifted[0];
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          // First DONE cycle registers the result; later cycles wait on the consumer.
          if (!out_valid) begin
            product   <= {h[WIDTH-3:0], q};
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
// tb/tb_booth_r4_mult.sv - directed self-checking bench for booth_r4_mult
module tb_booth_r4_mult;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid8, in_ready8, signed8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  logic        in_valid16, in_ready16, signed16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] product16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  booth_r4_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(signed8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .product(product8), .busy(busy8)
  );

  booth_r4_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .signed_mode(signed16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .product(product16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul8(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic signed [15:0] sx, sy;
    if (s) begin
      sx = $signed({{8{x[7]}}, x});
      sy = $signed({{8{y[7]}}, y});
      return 16'(sx * sy);
    end
    return 16'({8'h00, x} * {8'h00, y});
  endfunction

  // Accept edge is the first posedge; lat counts edges after it until out_valid is seen.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                      output logic [15:0] p, output int lat, output int nbusy);
    a8 = ta; b8 = tb; signed8 = ts; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    nbusy = int'(busy8);
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      nbusy += int'(busy8);
    end
    p = product8;
    if (out_ready8 && out_valid8) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic s; logic [15:0] exp; string tag; } vec_t;

  initial begin
    vec_t        vecs[6];
    logic [15:0] p;
    int          lat, nbusy;
    logic [7:0]  ra, rb;
    logic        rs;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff"};
    vecs[1] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, "s_ff_ff"};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080, "s_80_7f"};
    vecs[3] = '{8'h00, 8'h5A, 1'b1, 16'h0000, "s_00_5a"};
    vecs[4] = '{8'h80, 8'h7F, 1'b0, 16'h3F80, "u_80_7f"};
    vecs[5] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, "s_7f_7f"};

    rst = 1'b1;
    in_valid8 = 0; a8 = 0; b8 = 0; signed8 = 0; out_ready8 = 1;
    in_valid16 = 0; a16 = 0; b16 = 0; signed16 = 0; out_ready16 = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready8, 1);
    check("rst_out_valid", out_valid8, 0);
    check("rst_busy", busy8, 0);
    check("rst_product", product8, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run8(8'h80, 8'h80, 1'b1, p, lat, nbusy);
    check("s_80_80", p, 16'h4000);
    check("s_80_80_lat", lat, 6);
    check("s_80_80_busy", nbusy, 5);

    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].s, p, lat, nbusy);
      check(vecs[i].tag, p, vecs[i].exp);
    end

    for (int i = 0; i < 48; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run8(ra, rb, rs, p, lat, nbusy);
      check($sformatf("rnd%0d_%h_%h_%0d", i, ra, rb, rs), p, ref_mul8(ra, rb, rs));
    end

    // Backpressure: 18*52 = 936, then new operands offered while blocked.
    out_ready8 = 1'b0;
    run8(8'h12, 8'h34, 1'b1, p, lat, nbusy);
    check("bp_first", p, 16'h03A8);
    a8 = 8'h77; b8 = 8'h55; signed8 = 1'b0; in_valid8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid_%0d", i), out_valid8, 1);
      check($sformatf("bp_prod_%0d", i), product8, 16'h03A8);
      check($sformatf("bp_in_ready_%0d", i), in_ready8, 0);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("bp_released", out_valid8, 0);
    check("bp_prod_hold", product8, 16'h03A8);
    check("bp_idle", in_ready8, 1);

    // Reset asserted during the third CALC cycle.
    a8 = 8'h0F; b8 = 8'h0E; signed8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", busy8, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready8, 1);
    check("mid_rst_out_valid", out_valid8, 0);
    check("mid_rst_product", product8, 0);
    run8(8'h03, 8'h05, 1'b0, p, lat, nbusy);
    check("after_rst_3x5", p, 16'h000F);
    check("after_rst_lat", lat, 6);

    // WIDTH=16 corner.
    a16 = 16'h8000; b16 = 16'h8000; signed16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w16_8000_8000", product16, 32'h40000000);
    check("w16_lat", lat, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
